// File: rtl/ring_input_buffer.sv
// Ring router input stage: sorts packets into high/low slot arrays with per-slot route codes,
// frees slots on allocator grants and promotes starving low packets into the high array.
module ring_input_buffer #(
  parameter int unsigned PACKET_SIZE  = 49,
  parameter int unsigned BUFFER_SIZE  = 4,
  parameter logic [15:0] ROUTER_ID    = 16'd0,
  parameter logic [15:0] OUT_PORT     = 16'h0001,
  parameter logic [15:0] LOCAL_PORT   = 16'h0002,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [PACKET_SIZE-1:0]                  in_packet,
  input  logic                                    in_high,
  output logic                                    in_ready_high,
  output logic                                    in_ready_low,
  output logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0] buffer_high_prior,
  output logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0] buffer_low_prior,
  output logic [BUFFER_SIZE-1:0][15:0]            buffer_high_prior_route_info,
  output logic [BUFFER_SIZE-1:0][15:0]            buffer_low_prior_route_info,
  input  logic [15:0]                             grant_pos,
  input  logic                                    grant_valid,
  input  logic                                    grant_in_high,
  output logic [2:0]                              high_count,
  output logic [2:0]                              low_count
);

  localparam int unsigned IDX_W  = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int unsigned VB     = PACKET_SIZE - 1;
  localparam int unsigned WAIT_W = 16;

  logic [BUFFER_SIZE-1:0][WAIT_W-1:0]      wait_q, wait_n;
  logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0] high_n, low_n;
  logic [BUFFER_SIZE-1:0][15:0]            hroute_n, lroute_n;
  logic [2:0]                              hcnt_n, lcnt_n;

  logic             in_valid, ins_high, ins_low, grant_hit;
  logic [IDX_W-1:0] grant_idx;
  logic             hfree_ok, lfree_ok, pdst_ok, psrc_ok;
  logic [IDX_W-1:0] hfree_idx, lfree_idx, pdst_idx, psrc_idx;
  logic [15:0]      in_route;

  assign in_ready_high = (high_count < 3'(BUFFER_SIZE));
  assign in_ready_low  = (low_count  < 3'(BUFFER_SIZE));

  // Slot selection: all decisions use cycle-start occupancy
  always_comb begin
    in_valid  = in_packet[VB];
    ins_high  = in_valid && in_high  && in_ready_high;
    ins_low   = in_valid && !in_high && in_ready_low;
    grant_hit = grant_valid && (grant_pos < 16'(BUFFER_SIZE));
    grant_idx = grant_pos[IDX_W-1:0];
    in_route  = (in_packet[31:16] == ROUTER_ID) ? LOCAL_PORT : OUT_PORT;

    hfree_ok  = 1'b0;
    hfree_idx = '0;
    lfree_ok  = 1'b0;
    lfree_idx = '0;
    for (int i = int'(BUFFER_SIZE) - 1; i >= 0; i--) begin
      if (!buffer_high_prior[IDX_W'(i)][VB]) begin
        hfree_ok  = 1'b1;
        hfree_idx = IDX_W'(i);
      end
      if (!buffer_low_prior[IDX_W'(i)][VB]) begin
        lfree_ok  = 1'b1;
        lfree_idx = IDX_W'(i);
      end
    end

    // Promotion target skips the slot taken by a same-cycle high insert
    pdst_ok  = 1'b0;
    pdst_idx = '0;
    psrc_ok  = 1'b0;
    psrc_idx = '0;
    for (int i = int'(BUFFER_SIZE) - 1; i >= 0; i--) begin
      if (!buffer_high_prior[IDX_W'(i)][VB] && !(ins_high && hfree_idx == IDX_W'(i))) begin
        pdst_ok  = 1'b1;
        pdst_idx = IDX_W'(i);
      end
      if (buffer_low_prior[IDX_W'(i)][VB] && wait_q[IDX_W'(i)] == WAIT_W'(STARVE_LIMIT) &&
          !(grant_hit && !grant_in_high && grant_idx == IDX_W'(i))) begin
        psrc_ok  = 1'b1;
        psrc_idx = IDX_W'(i);
      end
    end
  end

  // Next-state: age, grant, insert, promote, then recount
  always_comb begin
    high_n   = buffer_high_prior;
    low_n    = buffer_low_prior;
    hroute_n = buffer_high_prior_route_info;
    lroute_n = buffer_low_prior_route_info;
    wait_n   = wait_q;
    hcnt_n   = '0;
    lcnt_n   = '0;

    for (int i = 0; i < int'(BUFFER_SIZE); i++) begin
      if (buffer_low_prior[IDX_W'(i)][VB] && wait_q[IDX_W'(i)] != WAIT_W'(STARVE_LIMIT)) begin
        wait_n[IDX_W'(i)] = wait_q[IDX_W'(i)] + WAIT_W'(1);
      end
    end

    if (grant_hit) begin
      if (grant_in_high) begin
        high_n[grant_idx]   = '0;
        hroute_n[grant_idx] = '0;
      end else begin
        low_n[grant_idx]    = '0;
        lroute_n[grant_idx] = '0;
        wait_n[grant_idx]   = '0;
      end
    end

    if (ins_high && hfree_ok) begin
      high_n[hfree_idx]   = in_packet;
      hroute_n[hfree_idx] = in_route;
    end
    if (ins_low && lfree_ok) begin
      low_n[lfree_idx]    = in_packet;
      lroute_n[lfree_idx] = in_route;
      wait_n[lfree_idx]   = '0;
    end

    if (psrc_ok && pdst_ok) begin
      high_n[pdst_idx]   = buffer_low_prior[psrc_idx];
      hroute_n[pdst_idx] = buffer_low_prior_route_info[psrc_idx];
      low_n[psrc_idx]    = '0;
      lroute_n[psrc_idx] = '0;
      wait_n[psrc_idx]   = '0;
    end

    for (int i = 0; i < int'(BUFFER_SIZE); i++) begin
      hcnt_n = hcnt_n + 3'(high_n[IDX_W'(i)][VB]);
      lcnt_n = lcnt_n + 3'(low_n[IDX_W'(i)][VB]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buffer_high_prior            <= '0;
      buffer_low_prior             <= '0;
      buffer_high_prior_route_info <= '0;
      buffer_low_prior_route_info  <= '0;
      wait_q                       <= '0;
      high_count                   <= '0;
      low_count                    <= '0;
    end else begin
      buffer_high_prior            <= high_n;
      buffer_low_prior             <= low_n;
      buffer_high_prior_route_info <= hroute_n;
      buffer_low_prior_route_info  <= lroute_n;
      wait_q                       <= wait_n;
      high_count                   <= hcnt_n;
      low_count                    <= lcnt_n;
    end
  end

endmodule
